// File: rtl/line_card_read_scheduler_pkg.sv
// line_card_read_scheduler_pkg: shared sizes, types and FSM states for the line card read scheduler.
package line_card_read_scheduler_pkg;
    localparam int NUM_LINECARD_PORTS = 24;
    localparam int FIFO_PTR_BITS      = 13;
    localparam int PORT_IDX_BITS      = 5;

    typedef logic [FIFO_PTR_BITS-1:0] fifo_ptr_t;
    typedef logic [PORT_IDX_BITS-1:0] port_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        BUSY
    } sched_state_t;
endpackage

// File: rtl/line_card_read_scheduler_rr_priority_pick.sv
// rr_priority_pick: combinational round-robin pick of the first request after i_last, wrapping to 0.
module rr_priority_pick
    import line_card_read_scheduler_pkg::*;
#(
    parameter int NUM_REQ = NUM_LINECARD_PORTS
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  port_idx_t          i_last,
    output logic               o_found,
    output port_idx_t          o_idx
);
    logic [NUM_REQ-1:0] w_upper;

    // Lowest request overall is the wrap fallback; lowest request above i_last overrides it.
    always_comb begin
        w_upper = '0;
        o_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) w_upper[i] = i_req[i] & (port_idx_t'(i) > i_last);
        for (int i = NUM_REQ - 1; i >= 0; i--) if (i_req[i]) o_idx = port_idx_t'(i);
        for (int i = NUM_REQ - 1; i >= 0; i--) if (w_upper[i]) o_idx = port_idx_t'(i);
    end

    assign o_found = |i_req;
endmodule

// File: rtl/line_card_read_scheduler.sv
// line_card_read_scheduler: round-robin grant of non-empty ingress FIFOs to the shared FIFO reader.
// Define LINECARD_SCHED_PRIORITY_EN to serve ports at or above HIGH_WATER occupancy first.
module line_card_read_scheduler
    import line_card_read_scheduler_pkg::*;
#(
    parameter int NUM_IN_PORTS = NUM_LINECARD_PORTS,
    parameter int PTR_BITS     = FIFO_PTR_BITS
`ifdef LINECARD_SCHED_PRIORITY_EN
    ,
    parameter logic [PTR_BITS-1:0] HIGH_WATER = PTR_BITS'(3072)
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PTR_BITS-1:0]     wr_ptr_committed [NUM_IN_PORTS],
    input  logic [PTR_BITS-1:0]     rd_ptr [NUM_IN_PORTS],
    input  logic [NUM_IN_PORTS-1:0] rd_ptr_reset,
    input  logic [NUM_IN_PORTS-1:0] port_enable,
    output logic                    grant_valid,
    input  logic                    grant_ready,
    output port_idx_t               grant_port,
    output logic [PTR_BITS-1:0]     grant_occupancy,
    input  logic                    done,
    output logic                    abort,
    output logic                    protocol_err
);
    sched_state_t            r_state, w_state;
    logic [NUM_IN_PORTS-1:0] w_req, r_req;
    logic [PTR_BITS-1:0]     w_occ [NUM_IN_PORTS];
    logic [PTR_BITS-1:0]     r_occ [NUM_IN_PORTS];
    logic                    w_found;
    port_idx_t               w_pick;
    logic                    r_grant_valid, w_grant_valid;
    port_idx_t               r_grant_port, w_grant_port;
    logic [PTR_BITS-1:0]     r_grant_occ, w_grant_occ;
    port_idx_t               r_last, w_last;
    logic                    r_abort, w_abort;
    logic                    r_err, w_err;

    always_comb begin
        for (int i = 0; i < NUM_IN_PORTS; i++) begin
            w_occ[i] = wr_ptr_committed[i] - rd_ptr[i];
            w_req[i] = (w_occ[i] != '0) & port_enable[i] & ~rd_ptr_reset[i];
        end
    end

    always_ff @(posedge clk) begin
        r_req <= rst_n ? w_req : '0;
        r_occ <= w_occ;
    end

`ifdef LINECARD_SCHED_PRIORITY_EN
    logic [NUM_IN_PORTS-1:0] w_hi;
    logic                    w_hi_found, w_rr_found;
    port_idx_t               w_hi_idx, w_rr_idx;

    always_comb begin
        for (int i = 0; i < NUM_IN_PORTS; i++) w_hi[i] = r_req[i] & (r_occ[i] >= HIGH_WATER);
    end

    rr_priority_pick #(.NUM_REQ(NUM_IN_PORTS)) u_pick_hi (
        .i_req(w_hi), .i_last(r_last), .o_found(w_hi_found), .o_idx(w_hi_idx)
    );
    rr_priority_pick #(.NUM_REQ(NUM_IN_PORTS)) u_pick_rr (
        .i_req(r_req), .i_last(r_last), .o_found(w_rr_found), .o_idx(w_rr_idx)
    );

    assign w_found = w_hi_found | w_rr_found;
    assign w_pick  = w_hi_found ? w_hi_idx : w_rr_idx;
`else
    rr_priority_pick #(.NUM_REQ(NUM_IN_PORTS)) u_pick (
        .i_req(r_req), .i_last(r_last), .o_found(w_found), .o_idx(w_pick)
    );
`endif

    // A reset of the granted FIFO wins over any handshake in the same cycle.
    always_comb begin
        w_state       = r_state;
        w_grant_valid = r_grant_valid;
        w_grant_port  = r_grant_port;
        w_grant_occ   = r_grant_occ;
        w_last        = r_last;
        w_abort       = 1'b0;
        w_err         = r_err | (done & (r_state != BUSY));
        if (r_state != IDLE && rd_ptr_reset[r_grant_port]) begin
            w_state       = IDLE;
            w_grant_valid = 1'b0;
            w_abort       = 1'b1;
            w_last        = r_grant_port;
        end else if (r_state == IDLE && w_found) begin
            w_state       = OFFER;
            w_grant_valid = 1'b1;
            w_grant_port  = w_pick;
            w_grant_occ   = r_occ[w_pick];
        end else if (r_state == OFFER && grant_ready) begin
            w_state       = BUSY;
            w_grant_valid = 1'b0;
            w_last        = r_grant_port;
        end else if (r_state == BUSY && done) begin
            w_state = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_grant_valid <= 1'b0;
            r_grant_port  <= '0;
            r_grant_occ   <= '0;
            r_last        <= port_idx_t'(NUM_IN_PORTS - 1);
            r_abort       <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_grant_valid <= w_grant_valid;
            r_grant_port  <= w_grant_port;
            r_grant_occ   <= w_grant_occ;
            r_last        <= w_last;
            r_abort       <= w_abort;
            r_err         <= w_err;
        end
    end

    assign grant_valid     = r_grant_valid;
    assign grant_port      = r_grant_port;
    assign grant_occupancy = r_grant_occ;
    assign abort           = r_abort;
    assign protocol_err    = r_err;
endmodule

// File: tb/tb_line_card_read_scheduler.sv
// tb_line_card_read_scheduler: scoreboard bench; accepted grants are popped and checked by a monitor.
module tb_line_card_read_scheduler;
    import line_card_read_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] wr [24];
    logic [12:0] rd [24];
    logic [23:0] rd_ptr_reset;
    logic [23:0] port_enable;
    logic        grant_valid;
    logic        grant_ready;
    port_idx_t   grant_port;
    logic [12:0] grant_occupancy;
    logic        done;
    logic        abort;
    logic        protocol_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_abort  = 0;
    int q_port[$];
    int q_occ[$];

    line_card_read_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .wr_ptr_committed(wr), .rd_ptr(rd),
        .rd_ptr_reset(rd_ptr_reset), .port_enable(port_enable),
        .grant_valid(grant_valid), .grant_ready(grant_ready),
        .grant_port(grant_port), .grant_occupancy(grant_occupancy),
        .done(done), .abort(abort), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (abort) n_abort++;
        if (rst_n && grant_valid && grant_ready) begin
            if (q_port.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_grant: got port %0d expected none", grant_port);
            end else begin
                chk("sb_grant_port", int'(grant_port), q_port.pop_front());
                chk("sb_grant_occ", int'(grant_occupancy), q_occ.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 24; i++) begin
            wr[i] = '0;
            rd[i] = '0;
        end
        rd_ptr_reset = '0;
        port_enable  = '1;
        grant_ready  = 1'b0;
        done         = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!grant_valid && n < 20) begin
            cyc(1);
            n++;
        end
        if (!grant_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: got no grant_valid expected one within 20 cycles");
        end
    endtask

    task automatic accept();
        wait_valid();
        grant_ready = 1'b1;
        cyc(1);
        grant_ready = 1'b0;
    endtask

    task automatic finish_frame(input int after_accept);
        cyc(after_accept - 1);
        done = 1'b1;
        cyc(1);
        done = 1'b0;
    endtask

    task automatic expect_grant(input int port, input int occ);
        q_port.push_back(port);
        q_occ.push_back(occ);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected one before 100us");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("rst_grant_valid", int'(grant_valid), 0);
        chk("rst_grant_port", int'(grant_port), 0);
        chk("rst_grant_occ", int'(grant_occupancy), 0);
        chk("rst_abort", int'(abort), 0);
        chk("rst_protocol_err", int'(protocol_err), 0);

        wr[5] = 13'h0010;
        expect_grant(5, 16);
        cyc(1);
        chk("lat_cycle1_valid", int'(grant_valid), 0);
        cyc(1);
        chk("lat_cycle2_valid", int'(grant_valid), 1);
        chk("lat_cycle2_port", int'(grant_port), 5);
        chk("lat_cycle2_occ", int'(grant_occupancy), 16);
        accept();
        rd[5] = 13'h0010;
        finish_frame(4);
        cyc(5);
        chk("single_back_idle", int'(grant_valid), 0);
        chk("single_no_abort", n_abort, 0);

        do_reset();
        wr[3]  = 13'd2;
        wr[7]  = 13'd3;
        wr[20] = 13'd4;
        expect_grant(3, 2);
        expect_grant(7, 3);
        expect_grant(20, 4);
        expect_grant(3, 2);
        repeat (4) begin
            accept();
            finish_frame(4);
        end

        do_reset();
        wr[9]  = 13'd5;
        wr[12] = 13'd7;
        expect_grant(9, 5);
        expect_grant(12, 7);
        accept();
        cyc(1);
        rd_ptr_reset[9] = 1'b1;
        rd[9] = 13'd5;
        cyc(1);
        chk("abort_pulse_high", int'(abort), 1);
        chk("abort_valid_low", int'(grant_valid), 0);
        rd_ptr_reset[9] = 1'b0;
        cyc(1);
        chk("abort_pulse_low", int'(abort), 0);
        chk("abort_count", n_abort, 1);
        chk("after_abort_valid", int'(grant_valid), 1);
        chk("after_abort_port", int'(grant_port), 12);
        accept();
        finish_frame(4);

        do_reset();
        wr[0] = 13'h0002;
        rd[0] = 13'h1FFE;
        wr[1] = 13'h1000;
        rd[1] = 13'h1000;
        wr[6] = 13'd9;
        port_enable[6] = 1'b0;
        expect_grant(0, 4);
        accept();
        rd[0] = 13'h0002;
        finish_frame(4);
        cyc(6);
        chk("wrap_empty_and_disabled_skipped", int'(grant_valid), 0);

        do_reset();
        chk("perr_clear", int'(protocol_err), 0);
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        chk("perr_set", int'(protocol_err), 1);
        cyc(5);
        chk("perr_sticky", int'(protocol_err), 1);
        do_reset();
        chk("perr_cleared_by_reset", int'(protocol_err), 0);

        wr[4] = 13'd1;
        wait_valid();
        chk("midrst_offer", int'(grant_valid), 1);
        rst_n = 1'b0;
        cyc(1);
        chk("midrst_valid", int'(grant_valid), 0);
        chk("midrst_port", int'(grant_port), 0);
        chk("midrst_occ", int'(grant_occupancy), 0);
        chk("midrst_no_abort", int'(abort), 0);
        do_reset();

        wr[1] = 13'd1;
        expect_grant(1, 1);
        accept();
        rd[1]  = 13'd1;
        wr[2]  = 13'd10;
        wr[15] = 13'd3100;
`ifdef LINECARD_SCHED_PRIORITY_EN
        expect_grant(15, 3100);
`else
        expect_grant(2, 10);
`endif
        finish_frame(4);
        accept();
        finish_frame(4);

        chk("scoreboard_drained", q_port.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
